// File: rtl/apmu_ibex_pkg.sv
// Shared PMU types: counter-interface opcodes and the counter-port arbiter states.
package apmu_ibex_pkg;

    typedef enum logic [1:0] {
        PMC_IDLE = 2'd0,
        PMC_REQ  = 2'd1,
        PMC_WFP  = 2'd2,
        PMC_WFO  = 2'd3
    } pmc_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WFX  = 2'd2
    } pmc_arb_state_e;

endpackage

// File: rtl/apmu_rr_picker.sv
// Round-robin picker: returns the first set request at or above rr_ptr, wrapping modulo NUM_REQ.
module apmu_rr_picker #(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    int               idx;
    logic [IDX_W-1:0] sel;

    // Scan from the farthest offset down so the nearest one at or after rr_ptr wins.
    always_comb begin
        valid  = |req;
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = IDX_W'(idx);
            if (req[sel]) begin
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/apmu_pmc_bus_arbiter.sv
// Shares one PMU counter-unit port between NUM_REQ masters, one outstanding transaction at a time,
// with the owner locked from the downstream grant until its rvalid.
module apmu_pmc_bus_arbiter
    import apmu_ibex_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  pmc_op_e [NUM_REQ-1:0]     req_op_i,
    input  logic [NUM_REQ-1:0][31:0]  req_addr_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ-1:0][31:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]        req_gnt_o,
    output logic [NUM_REQ-1:0]        req_rvalid_o,
    output logic [NUM_REQ-1:0]        req_err_o,
    output logic [31:0]               req_rdata_o,
    output pmc_op_e                   counter_op_o,
    output logic [31:0]               counter_addr_o,
    output logic                      counter_we_o,
    output logic [31:0]               counter_wdata_o,
    input  logic                      counter_gnt_i,
    input  logic                      counter_rvalid_i,
    input  logic                      counter_err_i,
    input  logic [31:0]               counter_rdata_i,
    output logic                      stray_rvalid_o,
    output logic [IDX_W-1:0]          owner_o
);

    pmc_arb_state_e     state_reg, state_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic               stray_reg, stray_next;

    logic [NUM_REQ-1:0] req_vld;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   sel;
    pmc_op_e            op;
    logic [NUM_REQ-1:0] gnt, rvalid, err;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_vld
        assign req_vld[gi] = (req_op_i[gi] != PMC_IDLE);
    end

    apmu_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req     (req_vld),
        .rr_ptr  (rr_ptr_reg),
        .valid   (pick_valid),
        .winner  (pick_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ARB_IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            stray_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            stray_reg  <= stray_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        stray_next  = stray_reg;
        sel         = owner_reg;
        op          = PMC_IDLE;
        gnt         = '0;
        rvalid      = '0;
        err         = '0;
        case (state_reg)
            ARB_REQ: begin
                if (counter_rvalid_i) begin
                    rvalid[owner_reg] = 1'b1;
                    err[owner_reg]    = counter_err_i;
                    state_next        = ARB_IDLE;
                end
            end
            ARB_WFX: begin
                // Wait ops stay asserted until the response; an owner dropping its op does not abort.
                if (counter_rvalid_i) begin
                    rvalid[owner_reg] = 1'b1;
                    err[owner_reg]    = counter_err_i;
                    state_next        = ARB_IDLE;
                end else begin
                    op = req_op_i[owner_reg];
                end
            end
            default: begin
                sel = pick_valid ? pick_idx : '0;
                if (pick_valid) begin
                    op            = req_op_i[pick_idx];
                    gnt[pick_idx] = counter_gnt_i;
                    if (counter_gnt_i) begin
                        owner_next  = pick_idx;
                        rr_ptr_next = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                        state_next  = (req_op_i[pick_idx] == PMC_REQ) ? ARB_REQ : ARB_WFX;
                    end
                end
                if (counter_rvalid_i) begin
                    stray_next = 1'b1;
                end
            end
        endcase
    end

    // Handshake outputs are forced quiet for the whole time reset is asserted, not just after the edge.
    assign counter_op_o    = rst_ni ? op : PMC_IDLE;
    assign req_gnt_o       = gnt & {NUM_REQ{rst_ni}};
    assign req_rvalid_o    = rvalid & {NUM_REQ{rst_ni}};
    assign req_err_o       = err & {NUM_REQ{rst_ni}};
    assign req_rdata_o     = counter_rdata_i;
    assign counter_addr_o  = req_addr_i[sel];
    assign counter_we_o    = req_we_i[sel];
    assign counter_wdata_o = req_wdata_i[sel];
    assign stray_rvalid_o  = stray_reg;
    assign owner_o         = owner_reg;

endmodule

// File: tb/tb_apmu_pmc_bus_arbiter.sv
// Bench for apmu_pmc_bus_arbiter: directed vector table, hand sequences and a randomized run against a model.
module tb_apmu_pmc_bus_arbiter;
    import apmu_ibex_pkg::*;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rst_ni = 1'b0;
    pmc_op_e [N-1:0]     req_op;
    logic [N-1:0][31:0]  req_addr;
    logic [N-1:0]        req_we;
    logic [N-1:0][31:0]  req_wdata;
    logic [N-1:0]        req_gnt, req_rvalid, req_err;
    logic [31:0]         req_rdata;
    pmc_op_e             counter_op;
    logic [31:0]         counter_addr, counter_wdata;
    logic                counter_we;
    logic                counter_gnt, counter_rvalid, counter_err;
    logic [31:0]         counter_rdata;
    logic                stray;
    logic [1:0]          owner;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    apmu_pmc_bus_arbiter #(.NUM_REQ(N)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .req_op_i         (req_op),
        .req_addr_i       (req_addr),
        .req_we_i         (req_we),
        .req_wdata_i      (req_wdata),
        .req_gnt_o        (req_gnt),
        .req_rvalid_o     (req_rvalid),
        .req_err_o        (req_err),
        .req_rdata_o      (req_rdata),
        .counter_op_o     (counter_op),
        .counter_addr_o   (counter_addr),
        .counter_we_o     (counter_we),
        .counter_wdata_o  (counter_wdata),
        .counter_gnt_i    (counter_gnt),
        .counter_rvalid_i (counter_rvalid),
        .counter_err_i    (counter_err),
        .counter_rdata_i  (counter_rdata),
        .stray_rvalid_o   (stray),
        .owner_o          (owner)
    );

    typedef struct {
        logic [7:0]  ops;
        logic        cgnt, crv, cerr;
        logic [31:0] rdata;
        logic [3:0]  e_gnt, e_rv, e_err;
        logic [1:0]  e_op;
        logic        e_stray;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic [7:0] ops, logic g, logic rv, logic er, logic [31:0] rd,
                                logic [3:0] eg, logic [3:0] erv, logic [3:0] eer, logic [1:0] eop,
                                logic es);
        vec_t v;
        v.ops = ops; v.cgnt = g; v.crv = rv; v.cerr = er; v.rdata = rd;
        v.e_gnt = eg; v.e_rv = erv; v.e_err = eer; v.e_op = eop; v.e_stray = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] ops, input logic g, input logic rv, input logic er,
                         input logic [31:0] rd);
        for (int i = 0; i < N; i++) begin
            req_op[i]    = pmc_op_e'(ops[2*i +: 2]);
            req_addr[i]  = 32'h20 * i;
            req_we[i]    = i[0];
            req_wdata[i] = 32'hA000_0000 + i;
        end
        counter_gnt = g; counter_rvalid = rv; counter_err = er; counter_rdata = rd;
    endtask

    task automatic step(input logic [7:0] ops, input logic g, input logic rv, input logic er,
                        input logic [31:0] rd);
        @(negedge clk);
        drive(ops, g, rv, er, rd);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Reference model state for the randomized run.
    bit  m_busy, m_wait, m_stray;
    int  m_owner, m_ptr;

    task automatic model_check(input int cyc);
        logic [3:0]  e_gnt, e_rv, e_err;
        logic [1:0]  e_op;
        logic [31:0] e_addr, e_wdata;
        int          w;
        e_gnt = '0; e_rv = '0; e_err = '0; e_op = 2'd0; w = -1;
        if (!m_busy) begin
            for (int k = N - 1; k >= 0; k--)
                if (req_op[(m_ptr + k) % N] != PMC_IDLE) w = (m_ptr + k) % N;
            e_addr  = (w >= 0) ? req_addr[w]  : req_addr[0];
            e_wdata = (w >= 0) ? req_wdata[w] : req_wdata[0];
            if (w >= 0) begin
                e_op = req_op[w];
                if (counter_gnt) e_gnt[w] = 1'b1;
            end
        end else begin
            e_addr  = req_addr[m_owner];
            e_wdata = req_wdata[m_owner];
            if (m_wait && !counter_rvalid) e_op = req_op[m_owner];
            if (counter_rvalid) begin
                e_rv[m_owner]  = 1'b1;
                e_err[m_owner] = counter_err;
            end
        end
        chk($sformatf("rnd%0d gnt", cyc), 32'(req_gnt), 32'(e_gnt));
        chk($sformatf("rnd%0d rvalid", cyc), 32'(req_rvalid), 32'(e_rv));
        chk($sformatf("rnd%0d err", cyc), 32'(req_err), 32'(e_err));
        chk($sformatf("rnd%0d op", cyc), 32'(counter_op), 32'(e_op));
        chk($sformatf("rnd%0d addr", cyc), counter_addr, e_addr);
        chk($sformatf("rnd%0d wdata", cyc), counter_wdata, e_wdata);
        chk($sformatf("rnd%0d stray", cyc), 32'(stray), 32'(m_stray));
        if (e_rv != 0) chk($sformatf("rnd%0d rdata", cyc), req_rdata, counter_rdata);
        // advance the model to the state after the coming clock edge
        if (!m_busy) begin
            if (counter_rvalid) m_stray = 1'b1;
            if (w >= 0 && counter_gnt) begin
                m_busy  = 1'b1;
                m_wait  = (req_op[w] != PMC_REQ);
                m_owner = w;
                m_ptr   = (w + 1) % N;
            end
        end else if (counter_rvalid) begin
            m_busy = 1'b0;
        end
    endtask

    initial begin
        //            ops    g  rv er rdata          gnt     rv      err     op stray
        tbl[0]  = mk(8'h10, 1, 0, 0, 32'h0,        4'b0100, 4'b0000, 4'b0000, 1, 0);
        tbl[1]  = mk(8'h00, 1, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 0);
        tbl[2]  = mk(8'h00, 1, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 0);
        tbl[3]  = mk(8'h00, 1, 1, 0, 32'hDEADBEEF, 4'b0000, 4'b0100, 4'b0000, 0, 0);
        tbl[4]  = mk(8'h55, 1, 0, 0, 32'h0,        4'b1000, 4'b0000, 4'b0000, 1, 0);
        tbl[5]  = mk(8'h55, 1, 1, 1, 32'h1234,     4'b0000, 4'b1000, 4'b1000, 0, 0);
        tbl[6]  = mk(8'h55, 1, 0, 0, 32'h0,        4'b0001, 4'b0000, 4'b0000, 1, 0);
        tbl[7]  = mk(8'h55, 1, 1, 0, 32'h5678,     4'b0000, 4'b0001, 4'b0000, 0, 0);
        for (int i = 8; i < 13; i++)
            tbl[i] = mk(8'h11, 0, 0, 0, 32'h0,     4'b0000, 4'b0000, 4'b0000, 1, 0);
        tbl[13] = mk(8'h11, 1, 0, 0, 32'h0,        4'b0100, 4'b0000, 4'b0000, 1, 0);
        tbl[14] = mk(8'h00, 1, 1, 0, 32'hCAFE,     4'b0000, 4'b0100, 4'b0000, 0, 0);
        tbl[15] = mk(8'h00, 1, 1, 1, 32'hBAD,      4'b0000, 4'b0000, 4'b0000, 0, 0);
        tbl[16] = mk(8'h00, 0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 1);
        tbl[17] = mk(8'h00, 0, 0, 0, 32'h0,        4'b0000, 4'b0000, 4'b0000, 0, 1);

        drive(8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        do_reset();
        #2;
        chk("reset gnt", 32'(req_gnt), 0);
        chk("reset rvalid", 32'(req_rvalid), 0);
        chk("reset op", 32'(counter_op), 0);
        chk("reset stray", 32'(stray), 0);
        chk("reset owner", 32'(owner), 0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].ops, tbl[i].cgnt, tbl[i].crv, tbl[i].cerr, tbl[i].rdata);
            chk($sformatf("vec%0d gnt", i), 32'(req_gnt), 32'(tbl[i].e_gnt));
            chk($sformatf("vec%0d rvalid", i), 32'(req_rvalid), 32'(tbl[i].e_rv));
            chk($sformatf("vec%0d err", i), 32'(req_err), 32'(tbl[i].e_err));
            chk($sformatf("vec%0d op", i), 32'(counter_op), 32'(tbl[i].e_op));
            chk($sformatf("vec%0d stray", i), 32'(stray), 32'(tbl[i].e_stray));
            if (tbl[i].e_rv != 0) chk($sformatf("vec%0d rdata", i), req_rdata, tbl[i].rdata);
        end

        // Round-robin fairness: all hold PMC_REQ, response on the cycle after each grant.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(8'h55, 1'b1, c[0], 1'b0, 32'(c));
            if (!c[0]) begin
                chk($sformatf("rr%0d gnt", c), 32'(req_gnt), 32'(1 << ((c / 2) % N)));
            end else begin
                chk($sformatf("rr%0d gnt", c), 32'(req_gnt), 0);
                chk($sformatf("rr%0d rvalid", c), 32'(req_rvalid), 32'(1 << ((c / 2) % N)));
            end
        end

        // Wait op: requester 1 PMC_WFP held 20 cycles while 0 and 3 queue behind it.
        do_reset();
        step(8'h08, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wfp gnt", 32'(req_gnt), 32'b0010);
        chk("wfp op", 32'(counter_op), 32'(PMC_WFP));
        for (int c = 1; c < 20; c++) begin
            step(8'h49, 1'b1, 1'b0, 1'b0, 32'h0);
            chk($sformatf("wfp%0d op", c), 32'(counter_op), 32'(PMC_WFP));
            chk($sformatf("wfp%0d gnt", c), 32'(req_gnt), 0);
        end
        step(8'h49, 1'b1, 1'b1, 1'b0, 32'h77);
        chk("wfp end op", 32'(counter_op), 32'(PMC_IDLE));
        chk("wfp end rvalid", 32'(req_rvalid), 32'b0010);
        chk("wfp end gnt", 32'(req_gnt), 0);
        step(8'h41, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wfp next gnt", 32'(req_gnt), 32'b1000);

        // Reset asserted asynchronously during a PMC_WFO wait, then a late response.
        do_reset();
        step(8'h03, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wfo gnt", 32'(req_gnt), 32'b0001);
        step(8'h03, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wfo held op", 32'(counter_op), 32'(PMC_WFO));
        #1 rst_ni = 1'b0;
        #1;
        chk("wfo rst op", 32'(counter_op), 32'(PMC_IDLE));
        chk("wfo rst gnt", 32'(req_gnt), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        step(8'h00, 1'b0, 1'b1, 1'b0, 32'h99);
        chk("late rvalid", 32'(req_rvalid), 0);
        chk("late stray pre", 32'(stray), 0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("late stray", 32'(stray), 1);

        // Randomized run against the reference model.
        do_reset();
        m_busy = 0; m_wait = 0; m_stray = 0; m_owner = 0; m_ptr = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                req_op[i]    = ($urandom_range(1, 0) == 0) ? PMC_IDLE : pmc_op_e'($urandom_range(3, 1));
                req_addr[i]  = $urandom;
                req_we[i]    = 1'($urandom);
                req_wdata[i] = $urandom;
            end
            counter_gnt    = ($urandom_range(9, 0) < 6);
            counter_rvalid = ($urandom_range(3, 0) == 0);
            counter_err    = 1'($urandom);
            counter_rdata  = $urandom;
            #2;
            model_check(c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apmu_pmc_bus_arbiter.md
Name: apmu_pmc_bus_arbiter

Overview:
- Shares one PMU counter-unit port between NUM_REQ per-core counter masters, e.g. several counter-interface masters in a multi-core cluster.
- Uses round-robin arbitration with one outstanding transaction at a time.
- Owner lock is held from the downstream grant until the downstream rvalid, so PMC_REQ, PMC_WFP and PMC_WFO transactions are never interleaved.
- Routes response data and error back to the owning requester only.

Parameters:
- NUM_REQ, 4, number of requesting masters (>=2).
- IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_op_i  in  NUM_REQ x pmc_op_e  per-requester counter op; PMC_IDLE means no request.
- req_addr_i  in  NUM_REQ x 32  per-requester counter address.
- req_we_i  in  NUM_REQ  per-requester write enable.
- req_wdata_i  in  NUM_REQ x 32  per-requester write data.
- req_gnt_o  out  NUM_REQ  grant, one-hot or zero.
- req_rvalid_o  out  NUM_REQ  response valid, one-hot or zero.
- req_err_o  out  NUM_REQ  response error, qualified by req_rvalid_o.
- req_rdata_o  out  32  response data, broadcast to all requesters, qualified by req_rvalid_o.
- counter_op_o  out  pmc_op_e  op to the counter unit.
- counter_addr_o  out  32  address to the counter unit.
- counter_we_o  out  1  write enable to the counter unit.
- counter_wdata_o  out  32  write data to the counter unit.
- counter_gnt_i  in  1  counter unit ready.
- counter_rvalid_i  in  1  counter unit response valid.
- counter_err_i  in  1  counter unit error.
- counter_rdata_i  in  32  counter unit read data.
- stray_rvalid_o  out  1  sticky flag; set by counter_rvalid_i while ARB_IDLE.
- owner_o  out  IDX_W  current or last owner index (debug).

Behaviour:
- Reset (async assert, sync deassert via flops):
  - state = ARB_IDLE, rr_ptr = 0, owner = 0, stray flag = 0.
  - All gnt/rvalid/err outputs are 0; counter_op_o = PMC_IDLE.
- Combinational paths:
  - All outputs are combinational from state, registers and inputs; no added latency.
  - Request to counter_op_o: 0 cycles. counter_rvalid_i to req_rvalid_o: 0 cycles.
- Arbitration (ARB_IDLE only):
  - Candidates: requesters with req_op_i != PMC_IDLE.
  - Winner: first candidate at or after rr_ptr, searching upward with modulo-NUM_REQ wrap.
  - The winner's op/addr/we/wdata drive the counter_* outputs.
  - With no candidate: counter_op_o = PMC_IDLE; addr/we/wdata = requester 0's values, don't-care.
- Grant: req_gnt_o[w] = counter_gnt_i & winner valid. Never more than one bit set.
- Handshake: counter_gnt_i & counter_op_o != PMC_IDLE in ARB_IDLE.
  - Latch owner = w.
  - Set rr_ptr = (w+1) mod NUM_REQ.
  - Go to ARB_REQ if the op is PMC_REQ, else ARB_WFX.
- ARB_REQ:
  - counter_op_o = PMC_IDLE; addr/we/wdata follow the owner.
  - All req_gnt_o = 0.
  - On counter_rvalid_i: pulse req_rvalid_o[owner]; req_err_o[owner] = counter_err_i; go to ARB_IDLE.
- ARB_WFX:
  - counter_op_o = req_op_i[owner], held for the counter unit's wait semantics; addr/we/wdata follow the owner.
  - All req_gnt_o = 0.
  - On counter_rvalid_i: force counter_op_o = PMC_IDLE that cycle; pulse rvalid/err to owner; go to ARB_IDLE.
  - If the owner drops its op to PMC_IDLE mid-wait, forward PMC_IDLE and stay in ARB_WFX until rvalid. There is no abort path.
- No new arbitration in the cycle rvalid returns. The next grant is possible the following cycle at the earliest, so there is one idle cycle between transactions.
- Stray response: counter_rvalid_i in ARB_IDLE is dropped, produces no req_rvalid_o, and sets stray_rvalid_o. The flag clears only on reset.
- Simultaneous requests: exactly one winner per rr_ptr rule. Losers see gnt=0 and must hold their request.
- Single requester: it wins every time regardless of rr_ptr.
- Reset mid-transaction: immediately returns to ARB_IDLE. A later counter_rvalid_i for the aborted transaction is treated as stray.
- Illegal state encoding: treated as ARB_IDLE.

Decomposition:
- Shared package apmu_ibex_pkg:
  - reuse pmc_op_e;
  - add typedef enum pmc_arb_state_e {ARB_IDLE, ARB_REQ, ARB_WFX}.
- One sub-module, apmu_rr_picker: parameterised NUM_REQ; inputs req vector and rr_ptr; outputs valid and winner index.
  - Pure combinational, reusable for other PMU arbiters.

Test Plan:
- Single request: NUM_REQ=4; req 2 PMC_REQ, addr 0x40, we=0; counter_gnt_i=1; rvalid 3 cycles later with rdata 0xDEADBEEF.
  - Expect req_gnt_o=4'b0100 for one cycle.
  - Expect req_rvalid_o=4'b0100 with req_rdata_o=0xDEADBEEF.
  - Expect rr_ptr=3 afterwards.
- Round-robin fairness: all 4 requesters hold PMC_REQ continuously, immediate rvalid.
  - Expect grant order 0,1,2,3,0, with one idle cycle between grants.
- Wait ops: req 1 PMC_WFP, rvalid after 20 cycles.
  - Expect counter_op_o=PMC_WFP held for the 20 cycles, then PMC_IDLE on the rvalid cycle.
  - Expect req 0 and req 3, requesting meanwhile, to see no gnt until after the rvalid.
- Back-pressure: counter_gnt_i=0 for 5 cycles with reqs 0 and 2 pending, rr_ptr=1.
  - Expect no gnt during the 5 cycles; req 2 wins when gnt rises.
- Error and stray response:
  - rvalid with err=1 in ARB_REQ: expect req_err_o[owner]=1 only.
  - rvalid in ARB_IDLE: expect stray_rvalid_o=1 and sticky, with no req_rvalid_o.
- Reset mid-WFO: assert rst_ni=0 asynchronously during ARB_WFX.
  - Expect counter_op_o=PMC_IDLE immediately, before the next clock edge.
  - After release, a late rvalid sets stray_rvalid_o.
